mul16_seq: RTL and testbench
============================

Name: mul16_seq

Overview:
Sequential 16-bit shift-and-add multiplier controller. It time-multiplexes a single ADD16 instance across up to 16 iterations to form a*b mod 2^16, matching the 16-bit Hack word. It sits beside the existing arithmetic blocks as a multi-cycle unit. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake.

Parameters:
EARLY_EXIT, 1, 1: stop iterating once the remaining multiplier bits are zero; 0: always run 16 iterations.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
in_valid  input  1  operands a, b valid
in_ready  output  1  block can accept operands
a  input  16  multiplicand
b  input  16  multiplier
res_valid  output  1  result valid
res_ready  input  1  consumer accepts result
result  output  16  a*b mod 2^16

Behaviour:
- Reset (reset_n low at a rising edge): state IDLE; mcand, mplier, acc and count (4-bit) all zero.
- Outputs during and after reset: in_ready=1 when reset_n=1, 0 while reset_n=0; res_valid=0; result=0.
- Reset mid-operation: an in-flight multiply is discarded with no result produced. The first accept is possible in the first cycle with reset_n high.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, res_valid=0.
  - DONE: in_ready=0, res_valid=1.
- in_ready and res_valid are pure decodes of state, with no combinational path from in_valid/res_ready.
- IDLE, on in_valid=1 (accept): mcand<=a, mplier<=b, acc<=0, count<=0.
  - If EARLY_EXIT=1 and b==0, go to DONE.
  - Otherwise go to RUN.
- RUN, each cycle:
  - acc <= mplier[0] ? ADD16(acc, mcand) : acc.
  - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
  - Adder carry-out beyond bit 15 is dropped; all arithmetic wraps mod 2^16.
- RUN exit to DONE, evaluated on current values:
  - EARLY_EXIT=1: when mplier[15:1]==0 or count==15.
  - EARLY_EXIT=0: when count==15.
- DONE: result=acc, held stable while res_valid=1 && res_ready=0. On res_ready=1, go to IDLE.
- result is 0 outside DONE.
- Latency, with the accept cycle as cycle 0 and k the MSB index of b:
  - EARLY_EXIT=1, b==0: res_valid high in cycle 1.
  - EARLY_EXIT=1, b!=0: res_valid high in cycle k+2.
  - EARLY_EXIT=0: res_valid high in cycle 17 for every b.
- Back-to-back: in the cycle a result is handed off, in_ready=0. A new operand can be accepted no earlier than the following cycle (IDLE).
- in_valid while not IDLE is ignored. a and b are sampled only on the accept edge, so later changes have no effect.
- A single ADD16 instance with operands (acc, mcand). Its output is used only when mplier[0]=1 in RUN.

Decomposition:
- Shared include file: word-width constant (16). State encodings stay local (IDLE=2'd0, RUN=2'd1, DONE=2'd2); 2'd3 is unreachable and recovers to IDLE.
- Reuses the existing ADD16 as its only sub-module. No new sub-module.
- The iteration counter is a local 4-bit register. INC16 is not used for it.

Test Plan:
- a=7, b=9 accepted cycle 0, res_ready=1 -> res_valid cycle 5, result=16'h003F, IDLE cycle 6.
- a=16'hFFFF, b=16'hFFFF -> result=16'h0001 (wrap), res_valid cycle 17. With EARLY_EXIT=0, a=3, b=1 -> result=3, res_valid cycle 17.
- a=16'h1234, b=0 -> res_valid cycle 1, result=0. Then a=16'h0100, b=16'h0100 -> result=16'h0000, res_valid cycle 10 after its accept.
- Backpressure: a=5, b=6 with res_ready=0 for 6 cycles after res_valid -> result=16'h001E held, in_ready=0, intervening in_valid with a=1, b=1 ignored. res_ready=1 -> IDLE next cycle.
- Reset mid-run: a=16'h00FF, b=16'h8000, reset_n=0 in cycle 4 -> cycle 5 outputs in_ready=0, res_valid=0, result=0. After release, a=2, b=3 yields result=6 with no stale result emitted.
- Back-to-back: in_valid held high with a sequence of operand pairs and res_ready=1 -> each result is correct, and each new accept occurs exactly 1 cycle after the previous handoff.

Source files
------------

// File: rtl/mul16_seq_pkg.sv
// mul16_seq_pkg: shared widths and word types for the sequential multiplier.
//   WORD_W : datapath width (one Hack word)
//   CNT_W  : iteration counter width (16 iterations max)
package mul16_seq_pkg;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  count_t;
endpackage

// File: rtl/mul16_seq_if.sv
// mul16_seq_if: operand/result handshake bundle for mul16_seq.
//   in_valid/in_ready   : operand handshake (a = multiplicand, b = multiplier)
//   res_valid/res_ready : result handshake (result = a*b mod 2^16)
//   master : producer/consumer side, slave : multiplier side
interface mul16_seq_if;
  import mul16_seq_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t a;
  word_t b;
  logic  res_valid;
  logic  res_ready;
  word_t result;

  modport master (
    output in_valid, a, b, res_ready,
    input  in_ready, res_valid, result
  );

  modport slave (
    input  in_valid, a, b, res_ready,
    output in_ready, res_valid, result
  );
endinterface

// File: rtl/mul16_seq_add16.sv
// mul16_seq_add16: 16-bit ripple adder (ADD16). Carry-out is dropped, so the
// sum wraps mod 2^16.
//   a_i, b_i : addends
//   sum_o    : a_i + b_i mod 2^16
module mul16_seq_add16
  import mul16_seq_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  output word_t sum_o
);
  assign sum_o = a_i + b_i;
endmodule

// File: rtl/mul16_seq.sv
// mul16_seq: shift-and-add 16x16 -> 16 multiplier sharing one ADD16 across
// up to 16 iterations.
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : operand/result handshake (slave side)
//   EARLY_EXIT : 1 stops once the remaining multiplier bits are zero,
//                0 always runs 16 iterations
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one shift-and-add iteration per cycle
// DONE  | result presented, held until res_ready
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  mul16_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q;
  word_t  mcand_q;
  word_t  mplier_q;
  word_t  acc_q;
  count_t count_q;
  word_t  sum;
  logic   run_last;

  mul16_seq_add16 u_add16 (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .sum_o (sum)
  );

  // Exit is decided on the pre-shift values: the iteration that consumes the
  // last set multiplier bit is still performed in this cycle.
  assign run_last = (count_q == count_t'(CNT_W'(WORD_W - 1))) ||
                    (EARLY_EXIT && (mplier_q[WORD_W-1:1] == '0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= (EARLY_EXIT && (bus.b == '0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (mplier_q[0]) acc_q <= sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (run_last) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.res_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready is suppressed while reset is asserted even though state is IDLE.
  assign bus.in_ready  = reset_n && (state_q == ST_IDLE);
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.result    = (state_q == ST_DONE) ? acc_q : '0;
endmodule

// File: tb/tb_mul16_seq.sv
module tb_mul16_seq;
  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        drv_valid;
  logic [15:0] drv_a;
  logic [15:0] drv_b;
  logic        drv_rr;
  int          n_cmp;
  int          n_mis;

  mul16_seq_if u_if1 ();
  mul16_seq_if u_if0 ();

  mul16_seq #(.EARLY_EXIT(1'b1)) u_dut_ee (.clk(clk), .reset_n(reset_n), .bus(u_if1));
  mul16_seq #(.EARLY_EXIT(1'b0)) u_dut_full (.clk(clk), .reset_n(reset_n), .bus(u_if0));

  assign u_if1.in_valid  = sel & drv_valid;
  assign u_if0.in_valid  = ~sel & drv_valid;
  assign u_if1.a         = drv_a;
  assign u_if0.a         = drv_a;
  assign u_if1.b         = drv_b;
  assign u_if0.b         = drv_b;
  assign u_if1.res_ready = drv_rr;
  assign u_if0.res_ready = drv_rr;

  logic        s_in_ready;
  logic        s_res_valid;
  logic [15:0] s_result;
  assign s_in_ready  = sel ? u_if1.in_ready  : u_if0.in_ready;
  assign s_res_valid = sel ? u_if1.res_valid : u_if0.res_valid;
  assign s_result    = sel ? u_if1.result    : u_if0.result;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: product modulo 2^16 and cycle of first res_valid after accept.
  function automatic logic [15:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = {16'd0, x} * {16'd0, y};
    return p[15:0];
  endfunction

  function automatic int ref_lat(input bit ee, input logic [15:0] y);
    if (!ee) return 17;
    if (y == 16'd0) return 1;
    for (int i = 15; i >= 0; i--) if (y[i]) return i + 2;
    return 1;
  endfunction

  task automatic do_op(input bit sel_i, input logic [15:0] a_v, input logic [15:0] b_v);
    int n;
    bit found;
    logic [15:0] exp_r;
    int exp_l;
    exp_r = ref_prod(a_v, b_v);
    exp_l = ref_lat(sel_i, b_v);
    sel = sel_i; drv_a = a_v; drv_b = b_v; drv_valid = 1'b1; drv_rr = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_in_ready !== 1'b1) begin n_mis++; $display("FAIL op_accept_ready sel=%0d got=%b want=1", sel_i, s_in_ready); end
    tick();
    drv_valid = 1'b0; drv_a = 16'($urandom); drv_b = 16'($urandom);
    n = 1; found = 1'b0;
    while (n <= 40) begin
      @(negedge clk);
      if (s_res_valid === 1'b1) begin found = 1'b1; break; end
      tick();
      n++;
    end
    n_cmp++;
    if (!found) begin
      n_mis++; $display("FAIL op_timeout sel=%0d a=%h b=%h got=no res_valid want=cycle %0d", sel_i, a_v, b_v, exp_l);
    end else begin
      if (n != exp_l) begin n_mis++; $display("FAIL op_latency sel=%0d a=%h b=%h got=%0d want=%0d", sel_i, a_v, b_v, n, exp_l); end
      n_cmp++; if (s_result !== exp_r) begin n_mis++; $display("FAIL op_result sel=%0d a=%h b=%h got=%h want=%h", sel_i, a_v, b_v, s_result, exp_r); end
      n_cmp++; if (s_in_ready !== 1'b0) begin n_mis++; $display("FAIL op_ready_in_done got=%b want=0", s_in_ready); end
    end
    tick();
    @(negedge clk);
    n_cmp++; if ({s_in_ready, s_res_valid} !== 2'b10) begin n_mis++; $display("FAIL op_back_idle got=%b want=10", {s_in_ready, s_res_valid}); end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sel = 1'b1; drv_valid = 1'b1; drv_a = 16'h1111; drv_b = 16'h2222; drv_rr = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (u_if1.in_ready !== 1'b0) begin n_mis++; $display("FAIL rst_in_ready_ee got=%b want=0", u_if1.in_ready); end
    n_cmp++; if (u_if1.res_valid !== 1'b0) begin n_mis++; $display("FAIL rst_res_valid_ee got=%b want=0", u_if1.res_valid); end
    n_cmp++; if (u_if1.result !== 16'd0) begin n_mis++; $display("FAIL rst_result_ee got=%h want=0000", u_if1.result); end
    n_cmp++; if (u_if0.in_ready !== 1'b0) begin n_mis++; $display("FAIL rst_in_ready_full got=%b want=0", u_if0.in_ready); end
    n_cmp++; if (u_if0.res_valid !== 1'b0) begin n_mis++; $display("FAIL rst_res_valid_full got=%b want=0", u_if0.res_valid); end
    n_cmp++; if (u_if0.result !== 16'd0) begin n_mis++; $display("FAIL rst_result_full got=%h want=0000", u_if0.result); end
    tick();
    reset_n = 1'b1; drv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (u_if1.in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_release_ready_ee got=%b want=1", u_if1.in_ready); end
    n_cmp++; if (u_if0.in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_release_ready_full got=%b want=1", u_if0.in_ready); end
    tick();
  endtask

  task automatic test_directed();
    do_op(1'b1, 16'd7, 16'd9);
    do_op(1'b1, 16'hFFFF, 16'hFFFF);
    do_op(1'b1, 16'h1234, 16'h0000);
    do_op(1'b1, 16'h0100, 16'h0100);
    do_op(1'b1, 16'hABCD, 16'h0001);
  endtask

  task automatic test_no_early_exit();
    do_op(1'b0, 16'd3, 16'd1);
    do_op(1'b0, 16'hFFFF, 16'hFFFF);
    do_op(1'b0, 16'h1234, 16'h0000);
    for (int i = 0; i < 3; i++) do_op(1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic test_random();
    logic [31:0] mask;
    for (int i = 0; i < 12; i++) begin
      mask = (32'd1 << $urandom_range(0, 16)) - 32'd1;
      do_op(1'b1, 16'($urandom), 16'($urandom & mask));
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit found;
    sel = 1'b1; drv_a = 16'd5; drv_b = 16'd6; drv_valid = 1'b1; drv_rr = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_accept got=%b want=1", s_in_ready); end
    tick();
    drv_valid = 1'b0;
    n = 1; found = 1'b0;
    while (n <= 40) begin
      @(negedge clk);
      if (s_res_valid === 1'b1) begin found = 1'b1; break; end
      tick();
      n++;
    end
    n_cmp++; if (!found) begin n_mis++; $display("FAIL bp_timeout got=no res_valid want=res_valid"); end
    tick();
    drv_valid = 1'b1; drv_a = 16'd1; drv_b = 16'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if ({s_res_valid, s_in_ready} !== 2'b10) begin n_mis++; $display("FAIL bp_hold_flags cyc=%0d got=%b want=10", i, {s_res_valid, s_in_ready}); end
      n_cmp++; if (s_result !== 16'h001E) begin n_mis++; $display("FAIL bp_hold_result cyc=%0d got=%h want=001e", i, s_result); end
      tick();
    end
    drv_rr = 1'b1; drv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_result !== 16'h001E) begin n_mis++; $display("FAIL bp_handoff_result got=%h want=001e", s_result); end
    tick();
    @(negedge clk);
    n_cmp++; if ({s_in_ready, s_res_valid} !== 2'b10) begin n_mis++; $display("FAIL bp_idle got=%b want=10", {s_in_ready, s_res_valid}); end
    n_cmp++; if (s_result !== 16'd0) begin n_mis++; $display("FAIL bp_idle_result got=%h want=0000", s_result); end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (s_res_valid !== 1'b0) begin n_mis++; $display("FAIL bp_no_ghost cyc=%0d got=%b want=0", i, s_res_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    sel = 1'b1; drv_a = 16'h00FF; drv_b = 16'h8000; drv_valid = 1'b1; drv_rr = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_in_ready !== 1'b1) begin n_mis++; $display("FAIL rmr_accept got=%b want=1", s_in_ready); end
    tick();
    drv_valid = 1'b0;
    tick(); tick(); tick();
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_in_ready !== 1'b0) begin n_mis++; $display("FAIL rmr_ready_in_reset got=%b want=0", s_in_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if ({s_in_ready, s_res_valid} !== 2'b00) begin n_mis++; $display("FAIL rmr_flags got=%b want=00", {s_in_ready, s_res_valid}); end
    n_cmp++; if (s_result !== 16'd0) begin n_mis++; $display("FAIL rmr_result got=%h want=0000", s_result); end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s_in_ready, s_res_valid} !== 2'b10) begin n_mis++; $display("FAIL rmr_release got=%b want=10", {s_in_ready, s_res_valid}); end
    tick();
    do_op(1'b1, 16'd2, 16'd3);
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [6];
    logic [15:0] pb [6];
    logic [15:0] exp_r;
    int idx, done_cnt, cyc, acc_cyc, ho_cyc, exp_l;
    bit have_ho, acc_now;
    for (int i = 0; i < 6; i++) begin
      pa[i] = 16'($urandom);
      pb[i] = 16'($urandom >> $urandom_range(0, 16));
    end
    sel = 1'b1; drv_rr = 1'b1;
    idx = 0; done_cnt = 0; cyc = 0; acc_cyc = 0; ho_cyc = 0; have_ho = 1'b0;
    exp_r = 16'd0; exp_l = 0;
    drv_a = pa[0]; drv_b = pb[0]; drv_valid = 1'b1;
    while (done_cnt < 6 && cyc < 400) begin
      acc_now = 1'b0;
      @(negedge clk);
      if (s_in_ready === 1'b1 && drv_valid) begin
        exp_r = ref_prod(pa[idx], pb[idx]);
        exp_l = ref_lat(1'b1, pb[idx]);
        if (have_ho) begin
          n_cmp++; if (cyc - ho_cyc != 1) begin n_mis++; $display("FAIL b2b_gap idx=%0d got=%0d want=1", idx, cyc - ho_cyc); end
        end
        acc_cyc = cyc; idx++; acc_now = 1'b1;
      end
      if (s_res_valid === 1'b1) begin
        n_cmp++; if (s_result !== exp_r) begin n_mis++; $display("FAIL b2b_result n=%0d got=%h want=%h", done_cnt, s_result, exp_r); end
        n_cmp++; if (cyc - acc_cyc != exp_l) begin n_mis++; $display("FAIL b2b_latency n=%0d got=%0d want=%0d", done_cnt, cyc - acc_cyc, exp_l); end
        n_cmp++; if (s_in_ready !== 1'b0) begin n_mis++; $display("FAIL b2b_ready_at_handoff got=%b want=0", s_in_ready); end
        ho_cyc = cyc; have_ho = 1'b1; done_cnt++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (idx < 6) begin drv_a = pa[idx]; drv_b = pb[idx]; end
        else drv_valid = 1'b0;
      end
    end
    drv_valid = 1'b0;
    n_cmp++; if (done_cnt != 6) begin n_mis++; $display("FAIL b2b_timeout got=%0d results want=6", done_cnt); end
    tick();
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    reset_n = 1'b0; sel = 1'b1; drv_valid = 1'b0; drv_a = 16'd0; drv_b = 16'd0; drv_rr = 1'b0;
    test_reset();
    test_directed();
    test_no_early_exit();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
